// File: rtl/sdram_port_arbiter.sv
// Two-client burst arbiter in front of sdram_top: grants one port at a time, counts
// per-word acks to find the end of a burst and aborts stalled bursts with a watchdog.
module sdram_port_arbiter #(
   parameter int ADDR_W    = 24,
   parameter int DATA_W    = 16,
   parameter int LEN_W     = 9,
   parameter int PRIO_MODE = 0,
   parameter int TIMEOUT   = 1023
) (
   input  logic              clk_50m,
   input  logic              rst,
   input  logic              c0_req,
   input  logic              c0_we,
   input  logic [ADDR_W-1:0] c0_addr,
   input  logic [LEN_W-1:0]  c0_len,
   input  logic [DATA_W-1:0] c0_wdata,
   output logic              c0_wdata_ack,
   output logic [DATA_W-1:0] c0_rdata,
   output logic              c0_rdata_vld,
   output logic              c0_done,
   output logic              c0_err,
   input  logic              c1_req,
   input  logic              c1_we,
   input  logic [ADDR_W-1:0] c1_addr,
   input  logic [LEN_W-1:0]  c1_len,
   input  logic [DATA_W-1:0] c1_wdata,
   output logic              c1_wdata_ack,
   output logic [DATA_W-1:0] c1_rdata,
   output logic              c1_rdata_vld,
   output logic              c1_done,
   output logic              c1_err,
   output logic [ADDR_W-1:0] sdram_wr_addr,
   output logic [DATA_W-1:0] sdram_wr_data,
   output logic              sdram_wr_req,
   output logic [LEN_W-1:0]  sdwr_bytes,
   input  logic              sdram_wr_ack,
   output logic [ADDR_W-1:0] sdram_rd_addr,
   input  logic [DATA_W-1:0] sdram_rd_data,
   output logic              sdram_rd_req,
   output logic [LEN_W-1:0]  sdrd_bytes,
   input  logic              sdram_rd_ack,
   input  logic              sdram_init_done,
   input  logic              sdram_busy,
   output logic [1:0]        dbg_state_o
);

   // Handshake: a client holds cN_req with we/addr/len until its cN_done pulse; the
   // sdram request is held until the first matching ack, and every matching ack moves one word.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_XFER  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              grant_q, grant_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              err_q, err_d;
   logic              rr_q, rr_d;
   logic              pick;
   logic              ack_match;
   logic              active;
   logic [LEN_W-1:0]  cnt_inc;

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         wd_q    <= '0;
         err_q   <= 1'b0;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
         rr_q    <= rr_d;
      end
   end

   assign ack_match = we_q ? sdram_wr_ack : sdram_rd_ack;
   assign cnt_inc   = cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      we_d    = we_q;
      addr_d  = addr_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      wd_d    = wd_q;
      err_d   = err_q;
      rr_d    = rr_q;
      pick    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sdram_init_done && !sdram_busy && (c0_req || c1_req)) begin
               if (c0_req && c1_req) pick = (PRIO_MODE == 1) ? 1'b0 : rr_q;
               else                  pick = c1_req;
               grant_d = pick;
               we_d    = pick ? c1_we   : c0_we;
               addr_d  = pick ? c1_addr : c0_addr;
               len_d   = pick ? c1_len  : c0_len;
               if (len_d == '0) len_d = LEN_W'(1);
               cnt_d   = '0;
               wd_d    = '0;
               err_d   = 1'b0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE, ST_XFER: begin
            if (ack_match) begin
               cnt_d = cnt_inc;
               wd_d  = '0;
               if (cnt_inc == len_q) state_d = ST_DONE;
               else                  state_d = ST_XFER;
            end else if (wd_q == WD_LAST) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         ST_DONE: begin
            // Favour the other port next time, including after an aborted burst.
            rr_d    = ~grant_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign active = (state_q == ST_ISSUE) || (state_q == ST_XFER);

   assign sdram_wr_req  = (state_q == ST_ISSUE) && we_q;
   assign sdram_rd_req  = (state_q == ST_ISSUE) && !we_q;
   assign sdram_wr_addr = we_q ? addr_q : '0;
   assign sdram_rd_addr = we_q ? '0 : addr_q;
   assign sdwr_bytes    = we_q ? len_q : '0;
   assign sdrd_bytes    = we_q ? '0 : len_q;
   assign sdram_wr_data = (active && we_q) ? (grant_q ? c1_wdata : c0_wdata) : '0;

   assign c0_wdata_ack = sdram_wr_ack && active && we_q && !grant_q;
   assign c1_wdata_ack = sdram_wr_ack && active && we_q && grant_q;
   assign c0_rdata_vld = sdram_rd_ack && active && !we_q && !grant_q;
   assign c1_rdata_vld = sdram_rd_ack && active && !we_q && grant_q;
   assign c0_rdata     = sdram_rd_data;
   assign c1_rdata     = sdram_rd_data;

   assign c0_done = (state_q == ST_DONE) && !grant_q;
   assign c1_done = (state_q == ST_DONE) && grant_q;
   assign c0_err  = c0_done && err_q;
   assign c1_err  = c1_done && err_q;

   assign dbg_state_o = state_q;

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single sdram_top user interface (write/read request/ack, 24-bit address, 9-bit burst length) between two requesters.
  - Port 0: CPU/memory bus.
  - Port 1: display/DMA fetch.
- Sequences one burst at a time. Gates issue on sdram_init_done and !sdram_busy.
- Counts per-word acks to detect burst end and routes data to the granted port.
- Sits between the client masters and sdram_top.

Parameters:
ADDR_W, 24, SDRAM address width {bank[1:0], row[12:0], col[8:0]}
DATA_W, 16, data word width
LEN_W, 9, burst length field width (words)
PRIO_MODE, 0, 0 = round-robin, 1 = port 0 fixed priority
TIMEOUT, 1023, max cycles without any sdram ack before abort (10-bit watchdog)

Ports:
clk_50m  in  1  system clock
rst  in  1  synchronous reset, active-high
cN_req  in  1  (N=0,1) request; held stable with we/addr/len until cN_done
cN_we  in  1  1 = write, 0 = read
cN_addr  in  ADDR_W  start address
cN_len  in  LEN_W  burst words; 0 treated as 1
cN_wdata  in  DATA_W  current write word
cN_wdata_ack  out  1  word consumed; client advances cN_wdata next cycle
cN_rdata  out  DATA_W  read word (copy of sdram_rd_data)
cN_rdata_vld  out  1  cN_rdata valid this cycle
cN_done  out  1  one-cycle pulse: transaction finished
cN_err  out  1  qualifies cN_done: transaction aborted by timeout
sdram_wr_addr  out  ADDR_W  to sdram_top
sdram_wr_data  out  DATA_W  to sdram_top
sdram_wr_req  out  1  to sdram_top
sdwr_bytes  out  LEN_W  to sdram_top
sdram_wr_ack  in  1  from sdram_top; one pulse per word written
sdram_rd_addr  out  ADDR_W  to sdram_top
sdram_rd_data  in  DATA_W  from sdram_top
sdram_rd_req  out  1  to sdram_top
sdrd_bytes  out  LEN_W  to sdram_top
sdram_rd_ack  in  1  from sdram_top; one pulse per valid read word
sdram_init_done  in  1  controller initialised
sdram_busy  in  1  controller busy (refresh or active op)

Behaviour:
- Reset (synchronous, rst=1 at clk_50m edge):
  - State IDLE; RR pointer favours port 0.
  - All req/done/err/wdata_ack/rdata_vld = 0; addr/bytes/wr_data outputs = 0; counters = 0.
  - Reset mid-burst drops sdram_*_req immediately. No cN_done is issued for the killed transaction.
- State machine:
  - IDLE: when sdram_init_done=1, sdram_busy=0 and any cN_req=1, latch grant, we, addr and len (0 becomes 1) -> ISSUE.
    - Both requesting in RR mode: grant the port not served last. RR pointer is updated on every completion.
    - Both requesting in PRIO_MODE=1: always grant port 0.
  - ISSUE: drive sdram_wr_req or sdram_rd_req=1 with the latched addr and bytes.
    - Hold until the first matching ack, then drop req the same cycle the ack is seen (req=0 from the next cycle) and go to XFER.
    - The first ack counts as word 1. If len=1, go straight to DONE.
  - XFER: count matching acks; when count==len -> DONE.
  - DONE: pulse cN_done for the granted port for one cycle; update the RR pointer -> IDLE.
    - A new grant is possible no earlier than the cycle after DONE.
- Latency: cN_req sampled in IDLE at edge k -> sdram_*_req=1 from edge k+1.
- Data routing:
  - sdram_wr_data is a combinational mux of the granted cN_wdata.
  - cN_wdata_ack = sdram_wr_ack & grant==N & write & state∈{ISSUE,XFER}.
  - cN_rdata = sdram_rd_data for both ports.
  - cN_rdata_vld = sdram_rd_ack & grant==N & read & state∈{ISSUE,XFER}.
- Acks are ignored in the following cases:
  - Acks of the opposite direction.
  - Acks in IDLE or DONE.
  - Acks beyond len.
- Watchdog:
  - Counter resets on every matching ack and on entry to ISSUE.
  - If it reaches TIMEOUT in ISSUE or XFER: drop req, pulse cN_done and cN_err together -> IDLE.
- Ungranted port: outputs stay 0. Its request stays pending with no loss.
- Arbitration does not change while a transaction is in flight. A client dropping cN_req mid-transaction is illegal, and the transaction still completes.

Test Plan:
- Reset hold: after rst=1 with sdram_init_done=0 and c0_req=1 (write, addr 0x000400, len 1, wdata 0x000F), no sdram_wr_req is issued. Raise init_done -> sdram_wr_req=1 on the next edge with sdram_wr_addr=0x000400, sdwr_bytes=1. Ack -> c0_wdata_ack=1, then c0_done one cycle later, err=0.
- Read burst: c1 read, addr 0x000400, len 4. Model returns 4 rd_ack pulses with data 0x000F, 0x0010, 0x0011, 0x0012 -> c1_rdata_vld ×4 with matching data; sdram_rd_req dropped after the first ack; c1_done after the 4th.
- Contention RR: c0 and c1 both request continuously (len 2 each) -> grants alternate 0,1,0,1; neither is starved. With PRIO_MODE=1 -> all grants go to port 0 while c0_req=1.
- Busy gating: sdram_busy=1 for 50 cycles while c0_req=1 -> no sdram req is issued; issue occurs one edge after busy falls.
- Timeout: c0 read, len 2, model never acks -> after 1023 cycles sdram_rd_req=0, c0_done=c0_err=1 for one cycle, state IDLE. A following c1 request is served normally.
- Reset mid-burst: rst=1 during XFER of a len 8 write -> next edge all outputs 0, no done pulse. A stray wr_ack after reset produces no c0/c1 activity.
